// File: rtl/bsg_fsb_pkg.sv
// Shared types for the front side bus hop blocks.
package bsg_fsb_pkg;

   // Output source chosen by the hop-out arbiter each cycle.
   typedef enum logic [2:0] {
      e_src_idle,
      e_src_local_starved,
      e_src_fifo,
      e_src_ring,
      e_src_local
   } bsg_fsb_hop_src_e;

   // Pointer width that stays legal for a depth of one.
   function automatic int unsigned bsg_fsb_safe_clog2(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/bsg_front_side_bus_hop_out_arb_if.sv
// Bus bundle for one hop-out arbiter: ring input, local valid/yumi input and
// the registered output toward the next hop.
interface bsg_front_side_bus_hop_out_arb_if #(
   parameter int unsigned width_p    = 16,
   parameter int unsigned fifo_els_p = 2
) ();

   localparam int unsigned count_w_lp = $clog2(fifo_els_p + 1);

   logic [width_p-1:0]    ring_data_i;
   logic                  ring_v_i;
   logic [width_p-1:0]    local_data_i;
   logic                  local_v_i;
   logic                  local_yumi_o;
   logic [width_p-1:0]    data_o;
   logic                  v_o;
   logic [count_w_lp-1:0] fifo_count_o;

   // Traffic source side (upstream hop plus local node).
   modport master (
      output ring_data_i, ring_v_i, local_data_i, local_v_i,
      input  local_yumi_o, data_o, v_o, fifo_count_o
   );

   // Arbiter side.
   modport slave (
      input  ring_data_i, ring_v_i, local_data_i, local_v_i,
      output local_yumi_o, data_o, v_o, fifo_count_o
   );

endinterface

// File: rtl/bsg_front_side_bus_hop_out_skid.sv
// Skid FIFO holding ring beats displaced by a starved local grant.
// Circular buffer with arbitrary depth; enqueue and dequeue may coincide.
module bsg_front_side_bus_hop_out_skid
   import bsg_fsb_pkg::*;
#(
   parameter int unsigned width_p = 16,
   parameter int unsigned els_p   = 2
) (
   input  logic                         clk_i,
   input  logic                         reset_i,
   input  logic                         enq_i,
   input  logic [width_p-1:0]           data_i,
   input  logic                         deq_i,
   output logic [width_p-1:0]           data_o,
   output logic [$clog2(els_p+1)-1:0]   count_o
);

   localparam int unsigned ptr_w_lp = bsg_fsb_safe_clog2(els_p);
   localparam int unsigned cnt_w_lp = $clog2(els_p + 1);
   localparam logic [ptr_w_lp-1:0] last_ptr_lp = ptr_w_lp'(els_p - 1);

   logic [width_p-1:0]  mem_q [els_p];
   logic [width_p-1:0]  mem_d [els_p];
   logic [ptr_w_lp-1:0] wr_ptr_q, wr_ptr_d;
   logic [ptr_w_lp-1:0] rd_ptr_q, rd_ptr_d;
   logic [cnt_w_lp-1:0] count_q, count_d;

   // Next-state for storage, pointers (wrap at els_p) and occupancy.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;

      if (enq_i) begin
         mem_d[wr_ptr_q] = data_i;
         wr_ptr_d = (wr_ptr_q == last_ptr_lp) ? '0 : wr_ptr_q + 1'b1;
      end

      if (deq_i) begin
         rd_ptr_d = (rd_ptr_q == last_ptr_lp) ? '0 : rd_ptr_q + 1'b1;
      end

      unique case ({enq_i, deq_i})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // State registers; reset discards any buffered beats.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         for (int i = 0; i < int'(els_p); i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign data_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/bsg_front_side_bus_hop_out_arb.sv
// Hop-out arbiter: merges unthrottled ring traffic with local valid/yumi
// injections. A local request starved for max_wait_p cycles is granted and
// the colliding ring beat is parked in the skid FIFO, which always drains
// ahead of new ring beats so ring order is preserved. Output is registered.
module bsg_front_side_bus_hop_out_arb
   import bsg_fsb_pkg::*;
#(
   parameter int unsigned width_p    = 16,
   parameter int unsigned fifo_els_p = 2,
   parameter int unsigned max_wait_p = 8
) (
   input  logic                        clk_i,
   input  logic                        reset_i,
   bsg_front_side_bus_hop_out_arb_if.slave bus
);

   localparam int unsigned cnt_w_lp  = $clog2(fifo_els_p + 1);
   localparam int unsigned wait_w_lp = $clog2(max_wait_p + 1);
   localparam logic [cnt_w_lp-1:0]  fifo_els_lp = cnt_w_lp'(fifo_els_p);
   localparam logic [wait_w_lp-1:0] max_wait_lp = wait_w_lp'(max_wait_p);

   bsg_fsb_hop_src_e     src;
   logic                 starved;
   logic                 room;
   logic                 fifo_enq;
   logic                 fifo_deq;
   logic [width_p-1:0]   fifo_data;
   logic [cnt_w_lp-1:0]  fifo_count;
   logic                 yumi;

   logic [wait_w_lp-1:0] wait_q, wait_d;
   logic [width_p-1:0]   data_q, data_d;
   logic                 v_q, v_d;

   bsg_front_side_bus_hop_out_skid #(
      .width_p (width_p),
      .els_p   (fifo_els_p)
   ) skid (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .enq_i   (fifo_enq),
      .data_i  (bus.ring_data_i),
      .deq_i   (fifo_deq),
      .data_o  (fifo_data),
      .count_o (fifo_count)
   );

   assign starved = (wait_q == max_wait_lp);
   assign room    = (fifo_count < fifo_els_lp);

   // Priority source select, handshake, FIFO control and output next-state.
   always_comb begin
      src      = e_src_idle;
      yumi     = 1'b0;
      fifo_enq = 1'b0;
      fifo_deq = 1'b0;
      data_d   = data_q;
      v_d      = 1'b0;

      if (bus.local_v_i && starved && room) begin
         src = e_src_local_starved;
      end else if (fifo_count != '0) begin
         src = e_src_fifo;
      end else if (bus.ring_v_i) begin
         src = e_src_ring;
      end else if (bus.local_v_i) begin
         src = e_src_local;
      end

      unique case (src)
         e_src_local_starved: begin
            yumi     = 1'b1;
            fifo_enq = bus.ring_v_i;
            data_d   = bus.local_data_i;
            v_d      = 1'b1;
         end
         e_src_fifo: begin
            fifo_deq = 1'b1;
            fifo_enq = bus.ring_v_i;
            data_d   = fifo_data;
            v_d      = 1'b1;
         end
         e_src_ring: begin
            data_d = bus.ring_data_i;
            v_d    = 1'b1;
         end
         e_src_local: begin
            yumi   = 1'b1;
            data_d = bus.local_data_i;
            v_d    = 1'b1;
         end
         default: begin
            v_d = 1'b0;
         end
      endcase
   end

   // Wait counter: saturating count of consecutive ungranted local-valid cycles.
   always_comb begin
      wait_d = wait_q;
      if (!bus.local_v_i || yumi) begin
         wait_d = '0;
      end else if (wait_q != max_wait_lp) begin
         wait_d = wait_q + 1'b1;
      end
   end

   // Output and wait-counter registers.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wait_q <= '0;
         data_q <= '0;
         v_q    <= 1'b0;
      end else begin
         wait_q <= wait_d;
         data_q <= data_d;
         v_q    <= v_d;
      end
   end

   assign bus.local_yumi_o = yumi;
   assign bus.data_o       = data_q;
   assign bus.v_o          = v_q;
   assign bus.fifo_count_o = fifo_count;

endmodule

// File: tb/tb_bsg_front_side_bus_hop_out_arb.sv
// Bench for the hop-out arbiter: reset values, a fixed vector table, directed
// starvation/drain/reset sequences and randomized traffic against a
// queue-based reference model.
module tb_bsg_front_side_bus_hop_out_arb;

   localparam int W    = 16;
   localparam int ELS  = 2;
   localparam int MAXW = 8;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   bsg_front_side_bus_hop_out_arb_if #(.width_p(W), .fifo_els_p(ELS)) bus ();

   bsg_front_side_bus_hop_out_arb #(
      .width_p    (W),
      .fifo_els_p (ELS),
      .max_wait_p (MAXW)
   ) dut (
      .clk_i   (clk),
      .reset_i (reset),
      .bus     (bus)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: parked ring beats, wait count, expected output.
   logic [W-1:0] mq[$];
   int           mwait;
   logic         mv;
   logic [W-1:0] mdata;
   logic         exp_yumi;
   logic         last_yumi;

   typedef struct {
      logic         rv;
      logic [W-1:0] rd;
      logic         lv;
      logic [W-1:0] ld;
      logic         yumi;
      logic         v;
      logic [W-1:0] d;
      int           cnt;
   } vec_t;

   vec_t tbl[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      mwait = 0;
      mv    = 1'b0;
      mdata = '0;
   endtask

   task automatic model_eval(input logic rv, input logic [W-1:0] rd,
                             input logic lv, input logic [W-1:0] ld);
      bit starved;
      bit room;
      starved  = (mwait == MAXW);
      room     = (mq.size() < ELS);
      exp_yumi = 1'b0;
      if (lv && starved && room) begin
         mv = 1'b1; mdata = ld; exp_yumi = 1'b1;
         if (rv) mq.push_back(rd);
      end else if (mq.size() > 0) begin
         mv = 1'b1; mdata = mq.pop_front();
         if (rv) mq.push_back(rd);
      end else if (rv) begin
         mv = 1'b1; mdata = rd;
      end else if (lv) begin
         mv = 1'b1; mdata = ld; exp_yumi = 1'b1;
      end else begin
         mv = 1'b0;
      end
      if (!lv || exp_yumi) mwait = 0;
      else if (mwait < MAXW) mwait++;
   endtask

   // One cycle: drive at negedge, check yumi, clock, check registered outputs.
   task automatic step(input logic rv, input logic [W-1:0] rd,
                       input logic lv, input logic [W-1:0] ld, input string tag);
      bus.ring_v_i     = rv;
      bus.ring_data_i  = rd;
      bus.local_v_i    = lv;
      bus.local_data_i = ld;
      #1;
      model_eval(rv, rd, lv, ld);
      last_yumi = bus.local_yumi_o;
      chk({tag, "_yumi"}, 32'(bus.local_yumi_o), 32'(exp_yumi));
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_v"}, 32'(bus.v_o), 32'(mv));
      chk({tag, "_data"}, 32'(bus.data_o), 32'(mdata));
      chk({tag, "_count"}, 32'(bus.fifo_count_o), 32'(mq.size()));
   endtask

   initial begin
      logic         lv_cur;
      logic [W-1:0] ld_cur;
      logic [W-1:0] ring_tag;
      int           density;

      bus.ring_v_i     = 1'b0;
      bus.ring_data_i  = '0;
      bus.local_v_i    = 1'b0;
      bus.local_data_i = '0;
      model_reset();

      // Reset state.
      @(negedge clk);
      @(negedge clk);
      chk("reset_v", 32'(bus.v_o), 32'd0);
      chk("reset_data", 32'(bus.data_o), 32'd0);
      chk("reset_count", 32'(bus.fifo_count_o), 32'd0);
      chk("reset_yumi", 32'(bus.local_yumi_o), 32'd0);
      reset = 1'b0;

      // Vector table: ring-only, local-only, idle hold, ring-over-local.
      tbl[0] = '{1'b1, 16'h00A1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h00A1, 0};
      tbl[1] = '{1'b1, 16'h00B2, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h00B2, 0};
      tbl[2] = '{1'b1, 16'h00C3, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h00C3, 0};
      tbl[3] = '{1'b0, 16'h0000, 1'b1, 16'h8D00, 1'b1, 1'b1, 16'h8D00, 0};
      tbl[4] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h8D00, 0};
      tbl[5] = '{1'b1, 16'h00E5, 1'b1, 16'h8F00, 1'b0, 1'b1, 16'h00E5, 0};
      tbl[6] = '{1'b0, 16'h0000, 1'b1, 16'h8F00, 1'b1, 1'b1, 16'h8F00, 0};
      tbl[7] = '{1'b1, 16'h0077, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0077, 0};
      for (int i = 0; i < 8; i++) begin
         bus.ring_v_i     = tbl[i].rv;
         bus.ring_data_i  = tbl[i].rd;
         bus.local_v_i    = tbl[i].lv;
         bus.local_data_i = tbl[i].ld;
         #1;
         model_eval(tbl[i].rv, tbl[i].rd, tbl[i].lv, tbl[i].ld);
         chk($sformatf("tbl%0d_yumi", i), 32'(bus.local_yumi_o), 32'(tbl[i].yumi));
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("tbl%0d_v", i), 32'(bus.v_o), 32'(tbl[i].v));
         chk($sformatf("tbl%0d_data", i), 32'(bus.data_o), 32'(tbl[i].d));
         chk($sformatf("tbl%0d_count", i), 32'(bus.fifo_count_o), 32'(tbl[i].cnt));
      end

      // Starvation with continuous ring: grants at cycles 8 and 17, then full.
      ld_cur = 16'h8001;
      for (int i = 0; i < 30; i++) begin
         step(1'b1, 16'h0100 + W'(i), 1'b1, ld_cur, "starve");
         if (i == 7)  chk("starve_pre_yumi", 32'(last_yumi), 32'd0);
         if (i == 8) begin
            chk("starve_grant_yumi", 32'(last_yumi), 32'd1);
            chk("starve_grant_data", 32'(bus.data_o), 32'h8001);
            chk("starve_grant_count", 32'(bus.fifo_count_o), 32'd1);
         end
         if (i == 9)  chk("starve_r8_next", 32'(bus.data_o), 32'h0108);
         if (i == 17) chk("starve_second_count", 32'(bus.fifo_count_o), 32'd2);
         if (i >= 26) chk("starve_full_nogrant", 32'(last_yumi), 32'd0);
         if (last_yumi) ld_cur = ld_cur + 1'b1;
      end

      // Ring stops: FIFO head first, then starved grant, then plain local.
      step(1'b0, '0, 1'b1, ld_cur, "drain0");
      chk("drain0_count", 32'(bus.fifo_count_o), 32'd1);
      chk("drain0_fifo_first", 32'(last_yumi), 32'd0);
      step(1'b0, '0, 1'b1, ld_cur, "drain1");
      chk("drain1_starved_yumi", 32'(last_yumi), 32'd1);
      ld_cur = ld_cur + 1'b1;
      step(1'b0, '0, 1'b1, ld_cur, "drain2");
      chk("drain2_fifo_before_local", 32'(last_yumi), 32'd0);
      chk("drain2_count", 32'(bus.fifo_count_o), 32'd0);
      step(1'b0, '0, 1'b1, ld_cur, "drain3");
      chk("drain3_local_yumi", 32'(last_yumi), 32'd1);
      ld_cur = ld_cur + 1'b1;
      step(1'b0, '0, 1'b0, '0, "gap");

      // Refill to two entries, then reset mid-traffic.
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 16'h0200 + W'(i), 1'b1, ld_cur, "refill");
         if (last_yumi) ld_cur = ld_cur + 1'b1;
      end
      chk("prereset_count", 32'(bus.fifo_count_o), 32'd2);
      chk("prereset_v", 32'(bus.v_o), 32'd1);
      bus.ring_v_i = 1'b1;
      bus.local_v_i = 1'b1;
      #2 reset = 1'b1;
      #1;
      chk("async_reset_v", 32'(bus.v_o), 32'd0);
      chk("async_reset_count", 32'(bus.fifo_count_o), 32'd0);
      chk("async_reset_yumi", 32'(bus.local_yumi_o), 32'd0);
      chk("async_reset_data", 32'(bus.data_o), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0, '0, "postreset");

      // Randomized traffic with bursty ring density; local obeys valid/yumi.
      lv_cur   = 1'b0;
      ld_cur   = 16'h8400;
      ring_tag = 16'h4000;
      density  = 60;
      for (int i = 0; i < 600; i++) begin
         logic rv;
         if (i % 50 == 0) begin
            case ($urandom_range(0, 2))
               0:       density = 98;
               1:       density = 60;
               default: density = 15;
            endcase
         end
         if (!lv_cur && ($urandom_range(0, 2) == 0)) begin
            lv_cur = 1'b1;
            ld_cur = ld_cur + 1'b1;
         end
         rv = ($urandom_range(0, 99) < density);
         step(rv, ring_tag, lv_cur, ld_cur, "rand");
         if (rv) ring_tag = ring_tag + 1'b1;
         if (last_yumi) lv_cur = 1'b0;
      end

      // Let everything drain.
      for (int i = 0; i < 6; i++) begin
         step(1'b0, '0, lv_cur, ld_cur, "final");
         if (last_yumi) lv_cur = 1'b0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Safety bound on total run time.
   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/bsg_front_side_bus_hop_out_arb.md
Name: bsg_front_side_bus_hop_out_arb

Overview:
- Output-side arbiter for one front side bus ring hop.
- Merges pass-through ring traffic, which has no flow control and must always be accepted, with local-node injections, which use valid/yumi.
- Ring order is always preserved. To prevent local starvation, the block grants a starved local request and parks the colliding ring beat in a small skid FIFO.
- The FIFO drains before any ring bypass. The output is registered, giving one cycle of latency to the next hop.

Parameters:
- width_p, "inv", packet width in bits.
- fifo_els_p, 2, skid FIFO depth; must be >= 1.
- max_wait_p, 8, number of consecutive ungranted local-valid cycles before the local request counts as starved; must be >= 1.

Ports:
- clk_i  input  1  clock
- reset_i  input  1  asynchronous, active-high reset
- ring_data_i  input  width_p  pass-through packet from the upstream hop input
- ring_v_i  input  1  ring packet valid; no backpressure exists
- local_data_i  input  width_p  local-node packet
- local_v_i  input  1  local packet valid; must stay high with stable data until yumi
- local_yumi_o  output  1  local packet consumed this cycle; combinational
- data_o  output  width_p  registered packet to the next hop
- v_o  output  1  registered valid to the next hop
- fifo_count_o  output  $clog2(fifo_els_p+1)  current skid FIFO occupancy

Behaviour:
- Async reset clears all of the following; any in-flight skid contents are discarded:
  - v_o = 0, data_o = 0
  - FIFO empty, fifo_count_o = 0
  - wait counter = 0, local_yumi_o = 0
- starved = (wait_cnt == max_wait_p); room = (count < fifo_els_p).
- Per-cycle source select, first match wins:
  1. LOCAL_STARVED: local_v_i & starved & room. Send local; enqueue ring beat if ring_v_i.
  2. FIFO: count > 0. Send FIFO head and dequeue; enqueue ring beat if ring_v_i, so net count is unchanged.
  3. RING: ring_v_i. Bypass the ring beat to the output.
  4. LOCAL: local_v_i. Send local.
  5. IDLE: v_o next = 0; data_o holds its value.
- local_yumi_o = 1 only when case 1 or case 4 is selected.
- The selected packet appears on data_o/v_o on the next cycle, giving 1-cycle latency for every source.
- Wait counter:
  - Increments, saturating at max_wait_p, when local_v_i & ~local_yumi_o.
  - Clears when local_yumi_o = 1 or local_v_i = 0.
  - Width is $clog2(max_wait_p+1).
- Ordering: ring beats leave in arrival order. A new ring beat never bypasses a non-empty FIFO.
- Overflow cannot occur:
  - Enqueue without dequeue happens only in case 1, which requires room.
  - Simultaneous enqueue/dequeue at full is legal.
- FIFO full with back-to-back ring traffic: local stays starved until a ring idle cycle lets the FIFO drain. This is intended; ring-rate guarantees take precedence.
- Local packets never reorder; there is a single local stream.
- No combinational path from ring_*_i to local_yumi_o exists, except via case 3 versus case 4 selection.

Decomposition:
- Add to bsg_fsb_pkg: enum bsg_fsb_hop_src_e {e_src_idle, e_src_local_starved, e_src_fifo, e_src_ring, e_src_local} for select and debug.
- Sub-module bsg_front_side_bus_hop_out_skid holds the skid FIFO:
  - circular buffer of fifo_els_p entries
  - read/write pointers with wrap at fifo_els_p (non-power-of-two supported)
  - occupancy counter
  - enq/deq handled in the same cycle
  - async reset
- The top level contains the select logic, the wait counter and the output registers.

Test Plan:
1. Reset mid-traffic: assert reset_i with 2 FIFO entries and v_o = 1 → v_o, fifo_count_o and local_yumi_o are 0 immediately (async); after release the old entries never appear.
2. Ring only: ring beats A,B,C on consecutive cycles, local idle → data_o = A,B,C one cycle later, fifo_count_o stays 0.
3. Local only: local_v_i = 1 with D, ring idle → local_yumi_o = 1 the same cycle, data_o = D next cycle, wait counter stays 0.
4. Starvation, max_wait_p = 8, fifo_els_p = 2:
   - Stimulus: continuous ring R0..Rn with local valid L.
   - Cycle 8: local_yumi_o = 1, output L, R8 enqueued, count = 1.
   - Following cycles: R8,R9,… follow in order.
   - After ring stops: count drains to 0, one beat per cycle.
5. FIFO full: same as scenario 4 with two starvation grants → count reaches 2; a third starved local is not granted while count = 2, and no beat is lost or duplicated.
6. Ring idle gap with FIFO non-empty and local valid → FIFO head is sent before local; case 4 is granted only after count = 0.
